vx_commit_unit: RTL and testbench



---
 rtl/vx_commit_unit.sv | 135 +++++++++++++
 tb/tb_vx_commit_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vx_commit_unit.sv
// Commit stage: per-slot round-robin arbitration over the execute-unit commit
// streams, one registered writeback per slot, retired-instruction counter,
// per-warp retirement pulses and a simulation snapshot of register values.
//
// Packet layout (flattened, MSB to LSB):
//   cmt_data : {uuid, wid, tmask, PC, rd, data, sop, eop, wb}
//   wb_data  : {uuid, wid, tmask, PC, rd, data, sop, eop}
// data packs lane t at bits [t*XLEN +: XLEN].
module vx_commit_unit #(
    parameter int NUM_UNITS   = 4,
    parameter int ISSUE_WIDTH = 1,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NUM_REGS    = 64,
    localparam int RW      = $clog2(NUM_REGS),
    localparam int WID_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int UUID_W  = 44,
    localparam int O_EOP   = 0,
    localparam int O_SOP   = 1,
    localparam int O_DATA  = 2,
    localparam int O_RD    = O_DATA + NUM_THREADS * XLEN,
    localparam int O_PC    = O_RD + RW,
    localparam int O_TMASK = O_PC + XLEN,
    localparam int O_WID   = O_TMASK + NUM_THREADS,
    localparam int O_UUID  = O_WID + WID_W,
    localparam int OUT_W   = O_UUID + UUID_W,
    localparam int IN_W    = OUT_W + 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [ISSUE_WIDTH-1:0][NUM_UNITS-1:0]       cmt_valid,
    output logic [ISSUE_WIDTH-1:0][NUM_UNITS-1:0]       cmt_ready,
    input  logic [ISSUE_WIDTH-1:0][NUM_UNITS-1:0][IN_W-1:0] cmt_data,
    output logic [ISSUE_WIDTH-1:0]                      wb_valid,
    output logic [ISSUE_WIDTH-1:0][OUT_W-1:0]           wb_data,
    output logic [63:0]                                 csr_instret,
    output logic [NUM_WARPS-1:0]                        sched_committed_warps,
    output logic [NUM_REGS-1:0][XLEN-1:0]               sim_wb_value
);

    localparam int UIDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

    logic [ISSUE_WIDTH-1:0][UIDX_W-1:0] rr_ptr_p0;
    logic [ISSUE_WIDTH-1:0][UIDX_W-1:0] grant_idx_p0;
    logic [ISSUE_WIDTH-1:0]             fire_p0;
    logic [ISSUE_WIDTH-1:0][IN_W-1:0]   sel_pkt_p0;
    logic [63:0]                        retire_cnt_p0;
    logic [NUM_WARPS-1:0]               retire_warps_p0;
    logic [ISSUE_WIDTH-1:0][XLEN-1:0]   lane_val_p1;

    // Round-robin grant: first valid unit at or after the pointer, wrapping.
    always_comb begin
        cmt_ready    = '0;
        grant_idx_p0 = '0;
        fire_p0      = '0;
        sel_pkt_p0   = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            for (int k = 0; k < NUM_UNITS; k++) begin
                int idx;
                idx = (int'(rr_ptr_p0[s]) + k) % NUM_UNITS;
                if (!fire_p0[s] && cmt_valid[s][idx]) begin
                    fire_p0[s]        = 1'b1;
                    cmt_ready[s][idx] = 1'b1;
                    grant_idx_p0[s]   = UIDX_W'(idx);
                    sel_pkt_p0[s]     = cmt_data[s][idx];
                end
            end
        end
    end

    // Retirement this cycle: only the final packet of an instruction counts.
    always_comb begin
        retire_cnt_p0   = '0;
        retire_warps_p0 = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            if (fire_p0[s] && sel_pkt_p0[s][O_EOP + 1]) begin
                retire_cnt_p0 = retire_cnt_p0 + 64'd1;
                retire_warps_p0[sel_pkt_p0[s][O_WID + 1 +: WID_W]] = 1'b1;
            end
        end
    end

    // ---- stage boundary p0 -> p1: latch winners, counters and warp pulses ----
    // Register the granted packet per slot and advance the arbiter pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_p0             <= '0;
            wb_valid              <= '0;
            wb_data               <= '0;
            csr_instret           <= '0;
            sched_committed_warps <= '0;
        end else begin
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                if (fire_p0[s]) begin
                    rr_ptr_p0[s] <= (int'(grant_idx_p0[s]) == NUM_UNITS - 1) ?
                                    '0 : grant_idx_p0[s] + UIDX_W'(1);
                    wb_data[s]   <= sel_pkt_p0[s][IN_W-1:1];
                    wb_valid[s]  <= sel_pkt_p0[s][0] &&
                                    (sel_pkt_p0[s][O_TMASK + 1 +: NUM_THREADS] != '0);
                end else begin
                    wb_valid[s]  <= 1'b0;
                end
            end
            csr_instret           <= csr_instret + retire_cnt_p0;
            sched_committed_warps <= retire_warps_p0;
        end
    end

    // Pick the lowest-indexed active lane's value from each writeback.
    always_comb begin
        lane_val_p1 = '0;
        for (int s = 0; s < ISSUE_WIDTH; s++) begin
            lane_val_p1[s] = wb_data[s][O_DATA +: XLEN];
            for (int t = NUM_THREADS - 1; t >= 0; t--) begin
                if (wb_data[s][O_TMASK + t])
                    lane_val_p1[s] = wb_data[s][O_DATA + t * XLEN +: XLEN];
            end
        end
    end

    // ---- stage boundary p1 -> p2: register-value snapshot ----
    // Later slots are assigned last, so the highest slot wins on equal rd.
    always_ff @(posedge clk) begin
        if (reset) begin
            sim_wb_value <= '0;
        end else begin
            for (int s = 0; s < ISSUE_WIDTH; s++) begin
                if (wb_valid[s] && (wb_data[s][O_RD +: RW] != '0))
                    sim_wb_value[wb_data[s][O_RD +: RW]] <= lane_val_p1[s];
            end
        end
    end

endmodule

// File: tb/tb_vx_commit_unit.sv
// Directed bench for vx_commit_unit with default parameters (1 slot, 4 units).
module tb_vx_commit_unit;

    localparam int NU = 4, NT = 4, XL = 32, RW = 6, WW = 2;
    localparam int O_EOP = 0, O_SOP = 1, O_DATA = 2;
    localparam int O_RD = O_DATA + NT * XL;
    localparam int O_PC = O_RD + RW;
    localparam int O_TMASK = O_PC + XL;
    localparam int O_WID = O_TMASK + NT;
    localparam int O_UUID = O_WID + WW;
    localparam int OUT_W = O_UUID + 44;
    localparam int IN_W = OUT_W + 1;

    logic                          clk = 1'b0;
    logic                          reset;
    logic [0:0][NU-1:0]            cmt_valid;
    logic [0:0][NU-1:0]            cmt_ready;
    logic [0:0][NU-1:0][IN_W-1:0]  cmt_data;
    logic [0:0]                    wb_valid;
    logic [0:0][OUT_W-1:0]         wb_data;
    logic [63:0]                   csr_instret;
    logic [3:0]                    sched_committed_warps;
    logic [63:0][XL-1:0]           sim_wb_value;

    int n_checks = 0;
    int n_errors = 0;

    vx_commit_unit dut (
        .clk                   (clk),
        .reset                 (reset),
        .cmt_valid             (cmt_valid),
        .cmt_ready             (cmt_ready),
        .cmt_data              (cmt_data),
        .wb_valid              (wb_valid),
        .wb_data               (wb_data),
        .csr_instret           (csr_instret),
        .sched_committed_warps (sched_committed_warps),
        .sim_wb_value          (sim_wb_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Packet builder: lane ln carries v, other lanes carry filler values.
    function automatic logic [IN_W-1:0] mk_pkt(input logic [1:0] wid, input logic [3:0] tmask,
                                               input logic [5:0] rd, input int ln,
                                               input logic [31:0] v, input logic sop,
                                               input logic eop, input logic wb);
        logic [NT*XL-1:0] d;
        for (int i = 0; i < NT; i++) d[i*XL +: XL] = 32'hA5A5_0000 | i;
        d[ln*XL +: XL] = v;
        return {44'h123, wid, tmask, 32'h8000_0000, rd, d, sop, eop, wb};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_gnt [6];

    initial begin
        exp_gnt = '{4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
        reset     = 1'b1;
        cmt_valid = '0;
        cmt_data  = '0;
        step();
        step();
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_instret", csr_instret, 64'd0);
        chk("rst_sched", 64'(sched_committed_warps), 64'd0);
        chk("rst_wb_data_rd", 64'(wb_data[0][O_RD +: RW]), 64'd0);
        reset = 1'b0;

        // Single ALU packet
        cmt_valid[0]   = 4'b0001;
        cmt_data[0][0] = mk_pkt(2'd2, 4'b0001, 6'd5, 0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t1_ready", 64'(cmt_ready[0]), 64'b0001);
        step();
        cmt_valid = '0;
        chk("t1_wb_valid", 64'(wb_valid), 64'd1);
        chk("t1_rd", 64'(wb_data[0][O_RD +: RW]), 64'd5);
        chk("t1_instret", csr_instret, 64'd1);
        chk("t1_sched", 64'(sched_committed_warps), 64'b0100);
        chk("t1_sim_early", 64'(sim_wb_value[5]), 64'd0);
        step();
        chk("t1_wb_valid_off", 64'(wb_valid), 64'd0);
        chk("t1_sched_off", 64'(sched_committed_warps), 64'd0);
        chk("t1_sim", 64'(sim_wb_value[5]), 64'hDEADBEEF);

        // Round-robin among ALU, LSU, SFU
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int u = 0; u < NU; u++)
            cmt_data[0][u] = mk_pkt(2'(u), 4'b0001, 6'(u + 1), 0, 32'h100 + u, 1'b1, 1'b1, 1'b1);
        cmt_valid[0] = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("t2_grant%0d", i), 64'(cmt_ready[0]), 64'(exp_gnt[i]));
            step();
        end
        cmt_valid = '0;
        chk("t2_instret", csr_instret, 64'd6);
        chk("t2_last_rd", 64'(wb_data[0][O_RD +: RW]), 64'd4);
        chk("t2_sched", 64'(sched_committed_warps), 64'b1000);

        // Two-packet LSU response retires once
        cmt_valid[0]   = 4'b0010;
        cmt_data[0][1] = mk_pkt(2'd1, 4'b0100, 6'd7, 2, 32'h1111_2222, 1'b1, 1'b0, 1'b1);
        #1;
        chk("t3_ready_a", 64'(cmt_ready[0]), 64'b0010);
        step();
        chk("t3_wb_a", 64'(wb_valid), 64'd1);
        chk("t3_instret_a", csr_instret, 64'd6);
        chk("t3_sched_a", 64'(sched_committed_warps), 64'd0);
        cmt_data[0][1] = mk_pkt(2'd1, 4'b0100, 6'd7, 2, 32'h3333_4444, 1'b0, 1'b1, 1'b1);
        #1;
        chk("t3_ready_b", 64'(cmt_ready[0]), 64'b0010);
        step();
        cmt_valid = '0;
        chk("t3_wb_b", 64'(wb_valid), 64'd1);
        chk("t3_instret_b", csr_instret, 64'd7);
        chk("t3_sched_b", 64'(sched_committed_warps), 64'b0010);
        chk("t3_sim_a", 64'(sim_wb_value[7]), 64'h1111_2222);
        step();
        chk("t3_sim_b", 64'(sim_wb_value[7]), 64'h3333_4444);

        // Store (wb=0) from SFU
        cmt_valid[0]   = 4'b1000;
        cmt_data[0][3] = mk_pkt(2'd1, 4'b0001, 6'd9, 0, 32'h55, 1'b1, 1'b1, 1'b0);
        #1;
        chk("t4_ready", 64'(cmt_ready[0]), 64'b1000);
        step();
        cmt_valid = '0;
        chk("t4_wb_valid", 64'(wb_valid), 64'd0);
        chk("t4_instret", csr_instret, 64'd8);
        chk("t4_sched", 64'(sched_committed_warps), 64'b0010);

        // Write to rd=0 is never recorded
        cmt_valid[0]   = 4'b0001;
        cmt_data[0][0] = mk_pkt(2'd0, 4'b0001, 6'd0, 0, 32'd7, 1'b1, 1'b1, 1'b1);
        #1;
        chk("t5_ready", 64'(cmt_ready[0]), 64'b0001);
        step();
        cmt_valid = '0;
        chk("t5_wb_valid", 64'(wb_valid), 64'd1);
        chk("t5_instret", csr_instret, 64'd9);
        chk("t5_sched", 64'(sched_committed_warps), 64'b0001);
        step();
        chk("t5_sim_r0", 64'(sim_wb_value[0]), 64'd0);

        // Empty thread mask suppresses writeback but still retires
        cmt_valid[0]   = 4'b0001;
        cmt_data[0][0] = mk_pkt(2'd3, 4'b0000, 6'd11, 0, 32'h77, 1'b1, 1'b1, 1'b1);
        step();
        cmt_valid = '0;
        chk("t6_wb_valid", 64'(wb_valid), 64'd0);
        chk("t6_instret", csr_instret, 64'd10);
        chk("t6_sched", 64'(sched_committed_warps), 64'b1000);

        // Reset with valid inputs pending
        cmt_valid[0] = 4'b1111;
        for (int u = 0; u < NU; u++)
            cmt_data[0][u] = mk_pkt(2'(u), 4'b0001, 6'(u + 20), 0, 32'h200 + u, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        chk("t7_wb_valid", 64'(wb_valid), 64'd0);
        chk("t7_instret", csr_instret, 64'd0);
        chk("t7_sched", 64'(sched_committed_warps), 64'd0);
        chk("t7_wb_data", 64'(wb_data[0][O_RD +: RW]), 64'd0);
        chk("t7_sim_r7", 64'(sim_wb_value[7]), 64'd0);
        reset = 1'b0;
        #1;
        chk("t7_first_grant", 64'(cmt_ready[0]), 64'b0001);
        step();
        cmt_valid = '0;
        chk("t7_rd", 64'(wb_data[0][O_RD +: RW]), 64'd20);
        chk("t7_instret_after", csr_instret, 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
